// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl
//    Sequencing controller behind the 4x3 keypad scanner. Qualifies the
//    scanner's intermittent key code into single press events (no
//    auto-repeat), assembles up to NDIGITS decimal digits into an entry
//    buffer ('*' = backspace, '#' = enter) and hands the finished code to a
//    consumer over a valid/ready interface.
//
//    Optional build macro: KEY_ENTRY_TIMEOUT_EN
//       defined   - inactivity timer clears a partial entry after
//                   TIMEOUT_CYCLES and pulses o_timeout
//       undefined - no timer, o_timeout tied low
//
// Ports
//    i_clk        system clock, rising edge
//    i_rst_n      asynchronous active-low reset
//    i_digit      scanner code: 0-9 digit, 10 '*', 11 '#', 12-15 no key
//    o_key_evt    one-cycle pulse per accepted press
//    o_key_code   code of the last accepted press (held)
//    o_entry_len  digits currently in the entry buffer
//    o_code       submitted BCD code, newest digit in [3:0], upper nibbles 0
//    o_len        digit count of o_code
//    o_valid      submitted code available
//    i_ready      consumer accepts o_code (ignored while o_valid is low)
//    o_err        one-cycle pulse on a rejected key action
//    o_timeout    one-cycle pulse when a partial entry times out
//
// State table
//    S_IDLE | no key seen, waiting for a non-idle sample
//    S_QUAL | counting consecutive identical samples of the candidate key
//    S_HELD | press accepted, waiting for a long idle run (release)
module key_entry_ctrl #(
   parameter int NDIGITS        = 4,
   parameter int QUAL_CYCLES    = 16,
   parameter int RELEASE_CYCLES = 200000,
   parameter int TIMEOUT_CYCLES = 250000000
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [3:0]                   i_digit,
   output logic                         o_key_evt,
   output logic [3:0]                   o_key_code,
   output logic [$clog2(NDIGITS+1)-1:0] o_entry_len,
   output logic [NDIGITS*4-1:0]         o_code,
   output logic [$clog2(NDIGITS+1)-1:0] o_len,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic                         o_err,
   output logic                         o_timeout
);

   localparam int LW = $clog2(NDIGITS+1);
   localparam int CW = NDIGITS*4;
   localparam int QW = $clog2(QUAL_CYCLES+1);
   localparam int RW = $clog2(RELEASE_CYCLES+1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_QUAL = 2'd1;
   localparam logic [1:0] S_HELD = 2'd2;

   localparam logic [3:0] KEY_MAX_DIGIT  = 4'd9;
   localparam logic [3:0] KEY_STAR       = 4'd10;
   localparam logic [3:0] KEY_FIRST_IDLE = 4'd12;

   localparam logic [LW-1:0] LEN_MAX  = LW'(NDIGITS);
   localparam logic [QW-1:0] QUAL_ONE = QW'(1);
   localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_CYCLES-1);
   localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYCLES-1);

   logic [1:0]    state_q, state_nx;
   logic [3:0]    cap_q, cap_nx;
   logic [QW-1:0] qcnt_q, qcnt_nx;
   logic [RW-1:0] rcnt_q, rcnt_nx;
   logic          smp_idle;
   logic          accept;

   logic [CW-1:0] buf_q, buf_nx;
   logic [LW-1:0] len_nx;
   logic [CW-1:0] code_nx;
   logic [LW-1:0] olen_nx;
   logic          valid_nx;
   logic          err_nx;
   logic          xfer;
   logic          tmo_hit;

   // Codes 12-14 are not produced by a healthy scanner; treat them like 15.
   assign smp_idle = (i_digit >= KEY_FIRST_IDLE);

   // ---------------------------------------------------------------------
   // Press qualification / release FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_nx = state_q;
      cap_nx   = cap_q;
      qcnt_nx  = qcnt_q;
      rcnt_nx  = rcnt_q;
      accept   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!smp_idle) begin
               cap_nx  = i_digit;
               qcnt_nx = QUAL_ONE;
               if (QUAL_CYCLES <= 1) begin
                  accept   = 1'b1;
                  qcnt_nx  = '0;
                  rcnt_nx  = '0;
                  state_nx = S_HELD;
               end else begin
                  state_nx = S_QUAL;
               end
            end
         end
         S_QUAL: begin
            if (smp_idle) begin
               qcnt_nx  = '0;
               state_nx = S_IDLE;
            end else if (i_digit != cap_q) begin
               cap_nx  = i_digit;
               qcnt_nx = QUAL_ONE;
            end else if (qcnt_q == QUAL_LAST) begin
               accept   = 1'b1;
               qcnt_nx  = '0;
               rcnt_nx  = '0;
               state_nx = S_HELD;
            end else begin
               qcnt_nx = qcnt_q + 1'b1;
            end
         end
         S_HELD: begin
            // The scanner only sees a key during its own column slot, so
            // idle gaps shorter than a full frame must not end the press.
            if (!smp_idle) begin
               rcnt_nx = '0;
            end else if (rcnt_q == REL_LAST) begin
               rcnt_nx  = '0;
               state_nx = S_IDLE;
            end else begin
               rcnt_nx = rcnt_q + 1'b1;
            end
         end
         default: begin
            qcnt_nx  = '0;
            rcnt_nx  = '0;
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cap_q   <= '0;
         qcnt_q  <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_nx;
         cap_q   <= cap_nx;
         qcnt_q  <= qcnt_nx;
         rcnt_q  <= rcnt_nx;
      end
   end

   // ---------------------------------------------------------------------
   // Inactivity timeout
   // ---------------------------------------------------------------------
`ifdef KEY_ENTRY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-1);

   logic [TW-1:0] tmo_cnt_q;

   // A key accepted in the same cycle wins over the timeout.
   assign tmo_hit = (o_entry_len != '0) && (tmo_cnt_q == TMO_LAST) && !accept;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt_q <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= tmo_hit;
         if (accept || (o_entry_len == '0) || tmo_hit) begin
            tmo_cnt_q <= '0;
         end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
      end
   end
`else
   assign tmo_hit   = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Entry buffer and output handshake
   // ---------------------------------------------------------------------
   assign xfer = o_valid && i_ready;

   always_comb begin
      buf_nx   = buf_q;
      len_nx   = o_entry_len;
      code_nx  = o_code;
      olen_nx  = o_len;
      valid_nx = o_valid && !xfer;
      err_nx   = 1'b0;
      if (accept) begin
         if (i_digit <= KEY_MAX_DIGIT) begin
            if (o_entry_len < LEN_MAX) begin
               buf_nx = (buf_q << 4) | CW'(i_digit);
               len_nx = o_entry_len + 1'b1;
            end else begin
               err_nx = 1'b1;
            end
         end else if (i_digit == KEY_STAR) begin
            if (o_entry_len != '0) begin
               buf_nx = buf_q >> 4;
               len_nx = o_entry_len - 1'b1;
            end else begin
               err_nx = 1'b1;
            end
         end else begin
            // '#': a fresh snapshot may replace one that is leaving this
            // very cycle, but never one the consumer has not yet taken.
            if (o_entry_len == '0) begin
               err_nx = 1'b1;
            end else if (o_valid && !xfer) begin
               err_nx = 1'b1;
            end else begin
               code_nx  = buf_q;
               olen_nx  = o_entry_len;
               valid_nx = 1'b1;
               buf_nx   = '0;
               len_nx   = '0;
            end
         end
      end else if (tmo_hit) begin
         buf_nx = '0;
         len_nx = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         buf_q       <= '0;
         o_entry_len <= '0;
         o_code      <= '0;
         o_len       <= '0;
         o_valid     <= 1'b0;
         o_key_evt   <= 1'b0;
         o_key_code  <= 4'd0;
         o_err       <= 1'b0;
      end else begin
         buf_q       <= buf_nx;
         o_entry_len <= len_nx;
         o_code      <= code_nx;
         o_len       <= olen_nx;
         o_valid     <= valid_nx;
         o_key_evt   <= accept;
         o_err       <= err_nx;
         if (accept) begin
            o_key_code <= i_digit;
         end
      end
   end

endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
Sequencing controller that sits behind the 4x3 keypad scanner.
- Qualifies the scanner's intermittent 4-bit key code into single press events, with no auto-repeat.
- Assembles up to NDIGITS decimal digits into an entry buffer. '*' is backspace; '#' is enter.
- Hands the completed code to a consumer over a valid/ready interface.

Parameters:
NDIGITS, 4, maximum digits per entry; o_code width is NDIGITS*4.
QUAL_CYCLES, 16, consecutive identical non-idle samples required to accept a press.
RELEASE_CYCLES, 200000, consecutive idle samples required to declare release; exceeds one full 3-column scan frame at 50 MHz.
TIMEOUT_CYCLES, 250000000, inactivity timeout in cycles; used only with the optional feature.

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_digit  in  4  scanner code: 0-9 digits, 10='*', 11='#', 15=no key; 12-14 treated as no key
o_key_evt  out  1  one-cycle pulse per accepted press
o_key_code  out  4  code of the last accepted press; valid with o_key_evt and held after
o_entry_len  out  $clog2(NDIGITS+1)  digits currently in the entry buffer
o_code  out  NDIGITS*4  submitted code, BCD, right-justified (newest digit at [3:0]), upper nibbles 0
o_len  out  $clog2(NDIGITS+1)  digit count of o_code
o_valid  out  1  submitted code available
i_ready  in  1  consumer accepts o_code
o_err  out  1  one-cycle pulse on a rejected key action
o_timeout  out  1  one-cycle pulse on entry timeout

Behaviour:
- Reset (async, i_rst_n low): FSM to S_IDLE; all counters, buffer, o_code, o_len and o_entry_len cleared; o_key_code=0; o_valid, o_key_evt, o_err and o_timeout all 0.
- FSM S_IDLE:
  - non-idle sample v -> S_QUAL; capture v; qual count=1.
- FSM S_QUAL:
  - sample==v: qual count +1. The sample that reaches QUAL_CYCLES accepts the press -> S_HELD.
  - different non-idle sample: recapture v; count=1.
  - idle sample -> S_IDLE; no event.
- FSM S_HELD:
  - release counter counts consecutive idle samples; any non-idle sample, including a different code, resets it to 0.
  - counter reaching RELEASE_CYCLES -> S_IDLE.
  - no second press is accepted while in S_HELD.
- Accept latency: o_key_evt, o_key_code and all resulting buffer, flag and o_err updates are registered, appearing the cycle after the qualifying sample.
- Key actions:
  - Digit 0-9: if entry len<NDIGITS, shift buffer left one nibble, insert digit at [3:0], len+1. Otherwise ignore and pulse o_err.
  - '*': if len>0, shift buffer right one nibble, zero-fill top nibble, len-1. If len==0, pulse o_err.
  - '#': if len==0, pulse o_err. If o_valid=1 and no transfer in that cycle, pulse o_err; buffer kept. Otherwise o_code<=buffer, o_len<=len, o_valid<=1, buffer and len cleared.
- Digits and '*' are still accepted into the buffer while o_valid is pending.
- Handshake:
  - Transfer occurs on a cycle with o_valid&&i_ready.
  - o_valid falls the next cycle unless a '#' is accepted in that same cycle, in which case the new snapshot loads and o_valid stays 1.
  - o_code and o_len are stable while o_valid=1.
  - i_ready is ignored while o_valid=0.
- o_key_evt and o_err may assert in the same cycle.

Optional Feature:
Macro KEY_ENTRY_TIMEOUT_EN.
- Defined:
  - Inactivity counter resets on every o_key_evt and whenever entry len==0.
  - Otherwise it increments each cycle.
  - Reaching TIMEOUT_CYCLES clears the buffer (len=0) and pulses o_timeout for one cycle.
  - A pending o_valid/o_code is unaffected.
  - If timeout and key accept coincide, the key action wins and the counter restarts.
- Not defined: no counter logic; o_timeout tied 0; TIMEOUT_CYCLES unused.

Test Plan:
Bench uses QUAL_CYCLES=4, RELEASE_CYCLES=20, NDIGITS=4, TIMEOUT_CYCLES=100.
1. i_ready=1; press 1,2,3,'#' (each 10 cycles held, then 30 idle) -> four o_key_evt pulses; o_valid high one cycle with o_code=16'h0123, o_len=3.
2. Press 1,2,3,4,5 -> fifth press gives o_key_evt+o_err, o_entry_len stays 4; then '#' -> o_code=16'h1234, o_len=4.
3. Press 7,8,'*',9,'#' -> o_code=16'h0079, o_len=2; then '*' on empty buffer -> o_err pulse, o_entry_len=0.
4. Code 5 for 3 cycles then 15 -> no o_key_evt. Key 6 held with 15-cycle idle gaps for 200 cycles -> exactly one o_key_evt; 20 idle cycles later FSM returns to S_IDLE.
5. i_ready=0; press 4,'#',6,'#' -> second '#' gives o_err; o_code=16'h0004 held, o_entry_len=1. Raise i_ready -> o_valid drops the next cycle. Assert i_rst_n=0 mid-S_HELD -> all outputs 0 immediately.
6. With KEY_ENTRY_TIMEOUT_EN: press 3, then idle 100 cycles -> o_timeout pulse, o_entry_len=0. Without the macro: o_timeout stays 0 and the buffer is retained.
